match_window_counter: RTL and testbench
=======================================

# match_window_counter

Downstream consumer of the 1010 sequence detector's match output `z`. It counts match pulses over fixed windows of `WIN_LEN` qualified bit-cycles. Each finished window's count goes out through a one-entry valid/ready output register. A sticky flag records results dropped because the consumer stalled. It sits between the detector and the status/statistics logic that reads match rates.

## Interface
- `WIN_LEN`, 16 — qualified bit-cycles per window; legal range 2..65535.
- `CNT_W`, 8 — width of the match count; legal range 1..16.
- `clk` in 1 — single clock; all state changes on its rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `en` in 1 — counting enable.
- `bit_valid` in 1 — qualifies the current cycle as one bit-cycle of the detector stream.
- `z` in 1 — detector match output; sampled only when `bit_valid`=1.
- `cnt_ready` in 1 — consumer accepts `cnt_data` when high together with `cnt_valid`.
- `ovr_clr` in 1 — synchronous clear of `overrun`.
- `cnt_data` out `CNT_W` — match count of the last completed window.
- `cnt_valid` out 1 — `cnt_data` holds an unconsumed result.
- `overrun` out 1 — sticky flag: a completed window was discarded.
- `busy` out 1 — high while in state RUN.

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN.
- IDLE→RUN when `en`=1.
- RUN→IDLE when `en`=0.
- Entering RUN clears the window position `pos` and the accumulator `acc`.
- In RUN, on a cycle with `bit_valid`=1:
  - `acc` increments if `z`=1.
  - `pos` increments.
- Cycles with `bit_valid`=0 change nothing.
- Window completion: a qualified cycle with `pos`=`WIN_LEN`-1.
  - The result `acc` + `z` (the final bit counts) is offered to the output register.
  - `pos` and `acc` return to 0 that same edge, so the next window starts with no gap.
- Output register load on completion:
  - Loads if `cnt_valid`=0, or if `cnt_valid`=1 and `cnt_ready`=1 in the same cycle (consume and reload together, no overrun).
  - Otherwise the new result is dropped, `overrun` sets, and `cnt_data` keeps the old value.
- `cnt_valid`:
  - Clears on a cycle with `cnt_valid`=1, `cnt_ready`=1 and no completion.
  - Stays set while `cnt_ready`=0. `cnt_data` must stay stable while `cnt_valid`=1.
- `en` dropping mid-window discards the partial window (`pos` and `acc` are not reported). A pending `cnt_data`/`cnt_valid` survives and can still be consumed in IDLE.
- `overrun`:
  - Clears on `ovr_clr`=1.
  - If `ovr_clr` and a new drop happen in the same cycle, `overrun` stays 1 (set wins).
- Widths:
  - `pos` uses $clog2(`WIN_LEN`) bits.
  - `acc` uses `CNT_W` bits.
  - Overflow handling is set under Configuration.

## Timing
- Reset values: FSM=IDLE, `pos`=0, `acc`=0, `cnt_data`=0, `cnt_valid`=0, `overrun`=0, `busy`=0.
- `busy` rises the cycle after `en` is first seen high.
- Latency: `cnt_valid` rises on the edge that samples the final qualified bit of a window.
  - The result is visible the cycle after that bit is presented.
- Minimum spacing between results is `WIN_LEN` cycles (`bit_valid` held high).
- All outputs are registered; there are no combinational input→output paths.
- Asserting `rst` mid-window returns every register to its reset value immediately, with no clock needed.

## Configuration
- `MATCH_CNT_SAT_EN` defined:
  - `acc` and the completion sum saturate at 2^`CNT_W`-1.
  - Further matches in that window leave the count at 2^`CNT_W`-1.
- `MATCH_CNT_SAT_EN` undefined:
  - `acc` and the completion sum wrap modulo 2^`CNT_W`.
- Both builds behave identically when `CNT_W` ≥ $clog2(`WIN_LEN`+1).

## Test plan
- Window count: `WIN_LEN`=16, `CNT_W`=8, `cnt_ready`=1, `bit_valid`=1. Drive `z`=1 on bit-cycles 3, 7, 11 and 15 (15 is the final bit) → `cnt_data`=4, with `cnt_valid` high for one cycle after bit 15.
- Gapped qualifiers: `bit_valid` toggles 1/0 and `z`=1 on every qualified cycle → completion after 16 qualified cycles (31 clocks), `cnt_data`=16.
- Overrun: `cnt_ready`=0 across two windows with counts 5 then 9 → `cnt_data` stays 5 and `overrun`=1. Then `cnt_ready`=1 and `ovr_clr` pulse → `cnt_valid` clears and `overrun`=0.
- Same-cycle consume and load: `cnt_ready` asserted exactly on the completion cycle while `cnt_valid`=1 → new count loaded, `cnt_valid` stays 1, `overrun`=0.
- Mid-window stop: `en` dropped at `pos`=9 with 3 matches counted, then re-enabled → no result reported; the next window counts from 0 and needs a full 16 qualified cycles.
- Overflow: `CNT_W`=3 with `z`=1 on all 16 bits → `cnt_data`=7 with `MATCH_CNT_SAT_EN` defined, 0 without. Also assert `rst` mid-window and check every output is 0 asynchronously.

Source files
------------

// File: rtl/match_window_counter.sv
// match_window_counter
//
// Counts match pulses from a 1010 sequence detector over fixed windows of
// WIN_LEN qualified bit-cycles. Each finished window's count is presented
// through a one-entry valid/ready output register. When a window finishes
// while the previous result is still unconsumed, the new result is dropped
// and a sticky overrun flag is raised.
//
// Optional feature macro: MATCH_CNT_SAT_EN
//   defined   -> the per-window count saturates at 2^CNT_W-1
//   undefined -> the per-window count wraps modulo 2^CNT_W
//
// Parameters:
//   WIN_LEN  qualified bit-cycles per window (2..65535)
//   CNT_W    width of the match count (1..16)
//
// Ports:
//   clk_i        clock, all state changes on its rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         counting enable (IDLE<->RUN)
//   bit_valid_i  qualifies the current cycle as one detector bit-cycle
//   z_i          detector match output, sampled only on qualified cycles
//   cnt_ready_i  consumer accepts cnt_data_o when high with cnt_valid_o
//   ovr_clr_i    synchronous clear of overrun_o
//   cnt_data_o   match count of the last completed window
//   cnt_valid_o  cnt_data_o holds an unconsumed result
//   overrun_o    sticky: a completed window was discarded
//   busy_o       high while in state RUN
module match_window_counter #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             bit_valid_i,
  input  logic             z_i,
  input  logic             cnt_ready_i,
  input  logic             ovr_clr_i,
  output logic [CNT_W-1:0] cnt_data_o,
  output logic             cnt_valid_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned PW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(WIN_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             overrun_q, overrun_d;

  logic             qual;
  logic             done;
  logic [CNT_W-1:0] acc_inc;

  // A bit is counted only while running with the enable still high; the
  // cycle in which en_i drops leaves RUN and throws the partial window away.
  assign qual = (state_q == RUN) && en_i && bit_valid_i;
  assign done = qual && (pos_q == POS_LAST);

  // Accumulator plus the current bit. The same value serves as the running
  // count and as the completion result, so the final bit is included.
`ifdef MATCH_CNT_SAT_EN
  assign acc_inc = (z_i && (acc_q != {CNT_W{1'b1}})) ? acc_q + CNT_W'(1) : acc_q;
`else
  assign acc_inc = acc_q + CNT_W'(z_i);
`endif

  // Window FSM and position/accumulator next state.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        // Held at zero so that entering RUN starts a clean window.
        pos_d = '0;
        acc_d = '0;
        if (en_i) state_d = RUN;
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          pos_d   = '0;
          acc_d   = '0;
        end else if (bit_valid_i) begin
          if (done) begin
            // Next window starts on the very next qualified cycle.
            pos_d = '0;
            acc_d = '0;
          end else begin
            pos_d = pos_q + PW'(1);
            acc_d = acc_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
        acc_d   = '0;
      end
    endcase
  end

  // One-entry output register and sticky overrun flag.
  always_comb begin
    cnt_data_d  = cnt_data_q;
    cnt_valid_d = cnt_valid_q;
    overrun_d   = overrun_q && !ovr_clr_i;
    if (done) begin
      if (!cnt_valid_q || cnt_ready_i) begin
        // Empty slot, or consume and reload in the same cycle.
        cnt_data_d  = acc_inc;
        cnt_valid_d = 1'b1;
      end else begin
        // Consumer stalled: keep the old result, flag the loss. Set wins
        // over a simultaneous clear.
        overrun_d = 1'b1;
      end
    end else if (cnt_valid_q && cnt_ready_i) begin
      cnt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      acc_q       <= '0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      acc_q       <= acc_d;
      cnt_data_q  <= cnt_data_d;
      cnt_valid_q <= cnt_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cnt_data_o  = cnt_data_q;
  assign cnt_valid_o = cnt_valid_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q == RUN);

endmodule

// File: tb/tb_match_window_counter.sv
module tb_match_window_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       bit_valid;
  logic       z;
  logic       cnt_ready;
  logic       ovr_clr;

  logic [7:0] cnt_data;
  logic       cnt_valid;
  logic       overrun;
  logic       busy;

  logic [2:0] s_cnt_data;
  logic       s_cnt_valid;
  logic       s_overrun;
  logic       s_busy;

  int total = 0;
  int bad   = 0;

`ifdef MATCH_CNT_SAT_EN
  localparam int SMALL_FULL = 7;
`else
  localparam int SMALL_FULL = 0;
`endif

  always #5 clk = ~clk;

  match_window_counter #(.WIN_LEN(16), .CNT_W(8)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .bit_valid_i (bit_valid),
    .z_i         (z),
    .cnt_ready_i (cnt_ready),
    .ovr_clr_i   (ovr_clr),
    .cnt_data_o  (cnt_data),
    .cnt_valid_o (cnt_valid),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  // Narrow-count instance sharing the same stimulus, for overflow behaviour.
  match_window_counter #(.WIN_LEN(16), .CNT_W(3)) u_small (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .bit_valid_i (bit_valid),
    .z_i         (z),
    .cnt_ready_i (cnt_ready),
    .ovr_clr_i   (ovr_clr),
    .cnt_data_o  (s_cnt_data),
    .cnt_valid_o (s_cnt_valid),
    .overrun_o   (s_overrun),
    .busy_o      (s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present 16 consecutive qualified bits; z follows zmask (bit 0 first).
  task automatic run_window(input logic [15:0] zmask);
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      z         = zmask[i];
      tick();
    end
    bit_valid = 1'b0;
    z         = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; bit_valid = 1'b0; z = 1'b0;
    cnt_ready = 1'b1; ovr_clr = 1'b0;

    // Reset state
    #3;
    chk("rst_data",    cnt_data,  0);
    chk("rst_valid",   cnt_valid, 0);
    chk("rst_overrun", overrun,   0);
    chk("rst_busy",    busy,      0);
    $display("reset: data=%0d valid=%0d overrun=%0d busy=%0d", cnt_data, cnt_valid, overrun, busy);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Enable: busy rises the cycle after en is seen
    en = 1'b1;
    tick();
    chk("en_busy", busy, 1);

    // Window count: matches on bits 3,7,11,15
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      z = (i == 3 || i == 7 || i == 11 || i == 15);
      tick();
      if (i == 14) chk("w1_not_yet", cnt_valid, 0);
    end
    bit_valid = 1'b0; z = 1'b0;
    chk("w1_valid", cnt_valid, 1);
    chk("w1_data",  cnt_data,  4);
    $display("window1: data=%0d valid=%0d", cnt_data, cnt_valid);
    tick();
    chk("w1_consumed", cnt_valid, 0);

    // Gapped qualifiers: 16 qualified cycles over 31 clocks, z=1 throughout
    for (int c = 0; c < 31; c++) begin
      bit_valid = (c % 2 == 0);
      z = 1'b1;
      tick();
      if (c == 29) chk("gap_not_yet", cnt_valid, 0);
    end
    bit_valid = 1'b0; z = 1'b0;
    chk("gap_valid", cnt_valid, 1);
    chk("gap_data",  cnt_data,  16);
    chk("ovf_small_valid", s_cnt_valid, 1);
    chk("ovf_small_data",  s_cnt_data,  SMALL_FULL);
    $display("gapped: data=%0d small_data=%0d", cnt_data, s_cnt_data);
    tick();
    chk("gap_consumed", cnt_valid, 0);

    // Overrun: consumer stalled across two windows (5 then 9)
    cnt_ready = 1'b0;
    run_window(16'h001F);
    chk("ovr_first_valid", cnt_valid, 1);
    chk("ovr_first_data",  cnt_data,  5);
    chk("ovr_first_flag",  overrun,   0);
    run_window(16'h01FF);
    chk("ovr_keep_valid", cnt_valid, 1);
    chk("ovr_keep_data",  cnt_data,  5);
    chk("ovr_flag",       overrun,   1);
    $display("overrun: data=%0d valid=%0d overrun=%0d", cnt_data, cnt_valid, overrun);
    cnt_ready = 1'b1; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr_valid", cnt_valid, 0);
    chk("ovr_clr_flag",  overrun,   0);

    // Same-cycle consume and load
    cnt_ready = 1'b0;
    run_window(16'h0003);
    chk("sc_first_data", cnt_data, 2);
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      z = (i < 3);
      cnt_ready = (i == 15);
      tick();
      if (i == 14) chk("sc_hold_data", cnt_data, 2);
    end
    bit_valid = 1'b0; z = 1'b0;
    chk("sc_valid",   cnt_valid, 1);
    chk("sc_data",    cnt_data,  3);
    chk("sc_overrun", overrun,   0);
    $display("same-cycle: data=%0d valid=%0d overrun=%0d", cnt_data, cnt_valid, overrun);
    cnt_ready = 1'b1;
    tick();
    chk("sc_consumed", cnt_valid, 0);

    // Mid-window stop at pos=9 with 3 matches, then restart
    for (int i = 0; i < 9; i++) begin
      bit_valid = 1'b1;
      z = (i < 3);
      tick();
    end
    en = 1'b0; bit_valid = 1'b0; z = 1'b0;
    tick();
    chk("stop_busy",  busy,      0);
    chk("stop_valid", cnt_valid, 0);
    tick();
    en = 1'b1;
    tick();
    chk("restart_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      z = (i < 15);
      tick();
      if (i == 14) chk("restart_not_yet", cnt_valid, 0);
    end
    bit_valid = 1'b0; z = 1'b0;
    chk("restart_valid", cnt_valid, 1);
    chk("restart_data",  cnt_data,  15);
    $display("restart: data=%0d valid=%0d", cnt_data, cnt_valid);

    // Asynchronous reset mid-window with a pending result
    cnt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      z = 1'b1;
      tick();
    end
    chk("pre_rst_valid", cnt_valid, 1);
    chk("pre_rst_data",  cnt_data,  15);
    chk("pre_rst_busy",  busy,      1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data",    cnt_data,    0);
    chk("arst_valid",   cnt_valid,   0);
    chk("arst_overrun", overrun,     0);
    chk("arst_busy",    busy,        0);
    chk("arst_s_data",  s_cnt_data,  0);
    chk("arst_s_valid", s_cnt_valid, 0);
    chk("arst_s_busy",  s_busy,      0);
    chk("arst_s_ovr",   s_overrun,   0);
    $display("async reset: data=%0d valid=%0d overrun=%0d busy=%0d", cnt_data, cnt_valid, overrun, busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
